// File: rtl/res_station_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | res_station_if                                                       |
// | Issue, common-data-bus and functional-unit handshake signals of one  |
// | reservation station, bundled for the station and its environment.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface res_station_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  // issue side (control unit)
  logic              issue_en;
  logic [1:0]        issue_op;
  logic [DATA_W-1:0] issue_vj;
  logic [DATA_W-1:0] issue_vk;
  logic [TAG_W-1:0]  issue_qj;
  logic [TAG_W-1:0]  issue_qk;
  logic [TAG_W-1:0]  issue_tag;
  logic              is_full;
  // common data bus
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  // functional unit handshake
  logic              exec_valid;
  logic              exec_ready;
  logic [1:0]        exec_op;
  logic [DATA_W-1:0] exec_a;
  logic [DATA_W-1:0] exec_b;
  logic [TAG_W-1:0]  exec_tag;

  modport master (
    output issue_en, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data, exec_ready,
    input  issue_tag, is_full, exec_valid, exec_op, exec_a, exec_b, exec_tag
  );

  modport slave (
    input  issue_en, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data, exec_ready,
    output issue_tag, is_full, exec_valid, exec_op, exec_a, exec_b, exec_tag
  );
endinterface
`default_nettype wire

// File: rtl/res_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | res_station                                                          |
// | Tomasulo reservation station: holds issued instructions until both   |
// | operands are known, offers ready ones to the functional unit and     |
// | frees an entry when its own tag is broadcast on the CDB.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module res_station #(
  parameter int DEPTH    = 3,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic         clk,
  input  logic         rst,
  res_station_if.slave bus
);

  localparam logic [1:0] ST_FREE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_EXEC  = 2'd3;

  // Entry i is permanently identified by tag TAG_BASE+i.
  function automatic logic [TAG_W-1:0] tag_of(input int idx);
    return TAG_W'(TAG_BASE + idx);
  endfunction

  logic [1:0]        state_q [DEPTH];
  logic [1:0]        state_d [DEPTH];
  logic [1:0]        op_q    [DEPTH];
  logic [1:0]        op_d    [DEPTH];
  logic [DATA_W-1:0] vj_q    [DEPTH];
  logic [DATA_W-1:0] vj_d    [DEPTH];
  logic [DATA_W-1:0] vk_q    [DEPTH];
  logic [DATA_W-1:0] vk_d    [DEPTH];
  logic [TAG_W-1:0]  qj_q    [DEPTH];
  logic [TAG_W-1:0]  qj_d    [DEPTH];
  logic [TAG_W-1:0]  qk_q    [DEPTH];
  logic [TAG_W-1:0]  qk_d    [DEPTH];

  logic [DEPTH-1:0]  alloc_oh;
  logic [DEPTH-1:0]  disp_oh;
  logic              alloc_found;
  logic              disp_found;
  logic [TAG_W-1:0]  issue_tag_w;
  logic [1:0]        exec_op_w;
  logic [DATA_W-1:0] exec_a_w;
  logic [DATA_W-1:0] exec_b_w;
  logic [TAG_W-1:0]  exec_tag_w;

  logic cdb_hit;
  logic issue_fire;
  logic dispatch_fire;

  // Entry registers; reset discards every entry, including dispatched ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        vj_q[i]    <= vj_d[i];
        vk_q[i]    <= vk_d[i];
        qj_q[i]    <= qj_d[i];
        qk_q[i]    <= qk_d[i];
      end
    end
  end

  // Priority pick of the lowest free entry (allocation) and lowest ready entry (offer).
  always_comb begin
    alloc_oh    = '0;
    disp_oh     = '0;
    alloc_found = 1'b0;
    disp_found  = 1'b0;
    issue_tag_w = tag_of(0);
    exec_op_w   = '0;
    exec_a_w    = '0;
    exec_b_w    = '0;
    exec_tag_w  = tag_of(0);
    for (int i = 0; i < DEPTH; i++) begin
      if (!alloc_found && state_q[i] == ST_FREE) begin
        alloc_found = 1'b1;
        alloc_oh[i] = 1'b1;
        issue_tag_w = tag_of(i);
      end
      if (!disp_found && state_q[i] == ST_READY) begin
        disp_found = 1'b1;
        disp_oh[i] = 1'b1;
        exec_op_w  = op_q[i];
        exec_a_w   = vj_q[i];
        exec_b_w   = vk_q[i];
        exec_tag_w = tag_of(i);
      end
    end
  end

  // Per-entry next state: each state reacts to exactly one event class, so
  // issue, capture, dispatch and release never collide on the same entry.
  always_comb begin
    cdb_hit       = bus.cdb_valid && (bus.cdb_tag != '0);
    issue_fire    = bus.issue_en && alloc_found;
    dispatch_fire = disp_found && bus.exec_ready;
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      vj_d[i]    = vj_q[i];
      vk_d[i]    = vk_q[i];
      qj_d[i]    = qj_q[i];
      qk_d[i]    = qk_q[i];
      case (state_q[i])
        ST_FREE: begin
          if (issue_fire && alloc_oh[i]) begin
            op_d[i] = bus.issue_op;
            // A source produced on the CDB this very cycle is taken directly.
            if (cdb_hit && bus.issue_qj == bus.cdb_tag) begin
              vj_d[i] = bus.cdb_data;
              qj_d[i] = '0;
            end else begin
              vj_d[i] = bus.issue_vj;
              qj_d[i] = bus.issue_qj;
            end
            if (cdb_hit && bus.issue_qk == bus.cdb_tag) begin
              vk_d[i] = bus.cdb_data;
              qk_d[i] = '0;
            end else begin
              vk_d[i] = bus.issue_vk;
              qk_d[i] = bus.issue_qk;
            end
            state_d[i] = (qj_d[i] == '0 && qk_d[i] == '0) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cdb_hit && qj_q[i] == bus.cdb_tag) begin
            vj_d[i] = bus.cdb_data;
            qj_d[i] = '0;
          end
          if (cdb_hit && qk_q[i] == bus.cdb_tag) begin
            vk_d[i] = bus.cdb_data;
            qk_d[i] = '0;
          end
          if (qj_d[i] == '0 && qk_d[i] == '0) begin
            state_d[i] = ST_READY;
          end
        end
        ST_READY: begin
          if (dispatch_fire && disp_oh[i]) begin
            state_d[i] = ST_EXEC;
          end
        end
        default: begin
          if (cdb_hit && bus.cdb_tag == tag_of(i)) begin
            state_d[i] = ST_FREE;
          end
        end
      endcase
    end
  end

  assign bus.issue_tag  = issue_tag_w;
  assign bus.is_full    = !alloc_found;
  assign bus.exec_valid = disp_found;
  assign bus.exec_op    = exec_op_w;
  assign bus.exec_a     = exec_a_w;
  assign bus.exec_b     = exec_b_w;
  assign bus.exec_tag   = exec_tag_w;

endmodule
`default_nettype wire

// File: tb/tb_res_station.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_res_station                                                       |
// | Self-checking bench for res_station: directed scenarios plus random  |
// | traffic compared against an entry-list reference model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_res_station;

  localparam int DEPTH    = 3;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int TAG_BASE = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  res_station_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  res_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .TAG_BASE(TAG_BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an entry is either empty or holds an instruction that
  // is either still in the station or already handed to the unit.
  bit          m_busy [DEPTH];
  bit          m_sent [DEPTH];
  logic [1:0]  m_op   [DEPTH];
  logic [31:0] m_vj   [DEPTH];
  logic [31:0] m_vk   [DEPTH];
  int          m_qj   [DEPTH];
  int          m_qk   [DEPTH];

  bit          e_full;
  int          e_itag;
  bit          e_valid;
  logic [1:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  int          e_tag;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_sent[i] = 0; m_op[i] = 0;
      m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
    end
  endfunction

  function automatic int model_free_idx();
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int model_ready_idx();
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && !m_sent[i] && m_qj[i] == 0 && m_qk[i] == 0) return i;
    return -1;
  endfunction

  function automatic void model_outs();
    int f;
    int r;
    f = model_free_idx();
    r = model_ready_idx();
    e_full  = (f < 0);
    e_itag  = (f < 0) ? TAG_BASE : TAG_BASE + f;
    e_valid = (r >= 0);
    e_op    = (r >= 0) ? m_op[r] : 2'd0;
    e_a     = (r >= 0) ? m_vj[r] : 32'd0;
    e_b     = (r >= 0) ? m_vk[r] : 32'd0;
    e_tag   = (r >= 0) ? TAG_BASE + r : TAG_BASE;
  endfunction

  // Apply one clock edge worth of events using the inputs present at the edge.
  function automatic void model_update();
    int  f;
    int  r;
    int  ct;
    bit  hit;
    f   = model_free_idx();
    r   = model_ready_idx();
    ct  = int'(bus.cdb_tag);
    hit = bus.cdb_valid && ct != 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && m_sent[i] && hit && ct == TAG_BASE + i) begin
        m_busy[i] = 0;
        m_sent[i] = 0;
      end else if (m_busy[i] && !m_sent[i] && hit) begin
        if (m_qj[i] == ct) begin m_vj[i] = bus.cdb_data; m_qj[i] = 0; end
        if (m_qk[i] == ct) begin m_vk[i] = bus.cdb_data; m_qk[i] = 0; end
      end
    end
    if (r >= 0 && bus.exec_ready) m_sent[r] = 1;
    if (bus.issue_en && f >= 0) begin
      m_busy[f] = 1;
      m_sent[f] = 0;
      m_op[f]   = bus.issue_op;
      m_qj[f]   = int'(bus.issue_qj);
      m_qk[f]   = int'(bus.issue_qk);
      m_vj[f]   = bus.issue_vj;
      m_vk[f]   = bus.issue_vk;
      if (hit && m_qj[f] == ct) begin m_vj[f] = bus.cdb_data; m_qj[f] = 0; end
      if (hit && m_qk[f] == ct) begin m_vk[f] = bus.cdb_data; m_qk[f] = 0; end
    end
  endfunction

  task automatic drive_idle();
    bus.issue_en   = 1'b0;
    bus.issue_op   = 2'd0;
    bus.issue_vj   = '0;
    bus.issue_vk   = '0;
    bus.issue_qj   = '0;
    bus.issue_qk   = '0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.exec_ready = 1'b0;
  endtask

  // One clock: inputs set by the caller are sampled at the edge, the model
  // follows, and inputs return to idle 1 time unit later.
  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
    model_outs();
    drive_idle();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    model_outs();
    drive_idle();
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic [3:0] qk);
    bus.issue_en = 1'b1;
    bus.issue_op = op;
    bus.issue_vj = vj;
    bus.issue_vk = vk;
    bus.issue_qj = qj;
    bus.issue_qk = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.is_full !== 1'b0 || bus.exec_valid !== 1'b0 || bus.issue_tag !== 4'd1 ||
        bus.exec_tag !== 4'd1 || bus.exec_op !== 2'd0 || bus.exec_a !== 32'd0 || bus.exec_b !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_values: full=%0b valid=%0b itag=%0d etag=%0d op=%0d a=%0h b=%0h, want 0 0 1 1 0 0 0",
               bus.is_full, bus.exec_valid, bus.issue_tag, bus.exec_tag, bus.exec_op, bus.exec_a, bus.exec_b);
    end
  endtask

  task automatic test_direct_issue();
    do_reset();
    issue(2'd2, 32'd5, 32'd7, 4'd0, 4'd0);
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_a !== 32'd5 || bus.exec_b !== 32'd7 ||
        bus.exec_tag !== 4'd1 || bus.exec_op !== 2'd2 || bus.issue_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL direct_offer: valid=%0b a=%0h b=%0h tag=%0d op=%0d itag=%0d, want 1 5 7 1 2 2",
               bus.exec_valid, bus.exec_a, bus.exec_b, bus.exec_tag, bus.exec_op, bus.issue_tag);
    end
    bus.exec_ready = 1'b1;
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b0 || bus.issue_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL direct_dispatched: valid=%0b itag=%0d, want 0 2", bus.exec_valid, bus.issue_tag);
    end
    cdb(4'd1, 32'h1234);
    clk_step();
    n_checks++;
    if (bus.issue_tag !== 4'd1 || bus.is_full !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_release: itag=%0d full=%0b, want 1 0", bus.issue_tag, bus.is_full);
    end
  endtask

  task automatic test_wait_capture();
    do_reset();
    issue(2'd1, 32'hDEAD, 32'd3, 4'd9, 4'd0);
    clk_step();
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b0 || bus.issue_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL wait_not_ready: valid=%0b itag=%0d, want 0 2", bus.exec_valid, bus.issue_tag);
    end
    cdb(4'd9, 32'h10);
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_a !== 32'h10 || bus.exec_b !== 32'd3 || bus.exec_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL wait_capture: valid=%0b a=%0h b=%0h tag=%0d, want 1 10 3 1",
               bus.exec_valid, bus.exec_a, bus.exec_b, bus.exec_tag);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    issue(2'd3, 32'h0, 32'h4, 4'd9, 4'd0);
    cdb(4'd9, 32'hAA);
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_a !== 32'hAA || bus.exec_b !== 32'h4) begin
      n_fail++;
      $display("FAIL issue_bypass: valid=%0b a=%0h b=%0h, want 1 aa 4", bus.exec_valid, bus.exec_a, bus.exec_b);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      issue(2'd0, 32'(i), 32'(10 + i), 4'd0, 4'd0);
      clk_step();
    end
    n_checks++;
    if (bus.is_full !== 1'b1 || bus.issue_tag !== 4'd1 || bus.exec_tag !== 4'd1) begin
      n_fail++;
      $display("FAIL full_flag: full=%0b itag=%0d etag=%0d, want 1 1 1", bus.is_full, bus.issue_tag, bus.exec_tag);
    end
    issue(2'd1, 32'h55, 32'h55, 4'd0, 4'd0);
    clk_step();
    n_checks++;
    if (bus.is_full !== 1'b1 || bus.exec_tag !== 4'd1 || bus.exec_a !== 32'd1) begin
      n_fail++;
      $display("FAIL full_drop: full=%0b etag=%0d a=%0h, want 1 1 1", bus.is_full, bus.exec_tag, bus.exec_a);
    end
    bus.exec_ready = 1'b1;
    clk_step();
    bus.exec_ready = 1'b1;
    clk_step();
    n_checks++;
    if (bus.exec_tag !== 4'd3 || bus.exec_a !== 32'd3) begin
      n_fail++;
      $display("FAIL full_dispatch_two: etag=%0d a=%0h, want 3 3", bus.exec_tag, bus.exec_a);
    end
    cdb(4'd3, 32'h0);
    clk_step();
    n_checks++;
    if (bus.is_full !== 1'b1 || bus.exec_tag !== 4'd3) begin
      n_fail++;
      $display("FAIL full_ignore_ready_tag: full=%0b etag=%0d, want 1 3", bus.is_full, bus.exec_tag);
    end
    cdb(4'd2, 32'h0);
    issue(2'd1, 32'h77, 32'h77, 4'd0, 4'd0);
    clk_step();
    n_checks++;
    if (bus.is_full !== 1'b0 || bus.issue_tag !== 4'd2) begin
      n_fail++;
      $display("FAIL full_release: full=%0b itag=%0d, want 0 2", bus.is_full, bus.issue_tag);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue(2'd1, 32'h11, 32'h1, 4'd0, 4'd0);
    clk_step();
    issue(2'd2, 32'h22, 32'h2, 4'd0, 4'd0);
    clk_step();
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_tag !== 4'd1 || bus.exec_a !== 32'h11) begin
      n_fail++;
      $display("FAIL backpressure_hold: valid=%0b tag=%0d a=%0h, want 1 1 11", bus.exec_valid, bus.exec_tag, bus.exec_a);
    end
    bus.exec_ready = 1'b1;
    clk_step();
    n_checks++;
    if (bus.exec_valid !== 1'b1 || bus.exec_tag !== 4'd2 || bus.exec_a !== 32'h22 || bus.exec_op !== 2'd2) begin
      n_fail++;
      $display("FAIL backpressure_next: valid=%0b tag=%0d a=%0h op=%0d, want 1 2 22 2",
               bus.exec_valid, bus.exec_tag, bus.exec_a, bus.exec_op);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(2'd1, 32'h1, 32'h2, 4'd0, 4'd0);
    clk_step();
    issue(2'd2, 32'h3, 32'h4, 4'd0, 4'd0);
    bus.exec_ready = 1'b1;
    clk_step();
    #3 rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (bus.is_full !== 1'b0 || bus.exec_valid !== 1'b0 || bus.issue_tag !== 4'd1 ||
        bus.exec_tag !== 4'd1 || bus.exec_a !== 32'd0 || bus.exec_b !== 32'd0 || bus.exec_op !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: full=%0b valid=%0b itag=%0d etag=%0d a=%0h b=%0h op=%0d, want 0 0 1 1 0 0 0",
               bus.is_full, bus.exec_valid, bus.issue_tag, bus.exec_tag, bus.exec_a, bus.exec_b, bus.exec_op);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cdb(4'd1, 32'h9);
    clk_step();
    n_checks++;
    if (bus.issue_tag !== 4'd1 || bus.is_full !== 1'b0 || bus.exec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_release: itag=%0d full=%0b valid=%0b, want 1 0 0",
               bus.issue_tag, bus.is_full, bus.exec_valid);
    end
  endtask

  function automatic logic [3:0] rand_src_tag();
    int s;
    s = int'($urandom_range(0, 9));
    if (s < 5) return 4'd0;
    if (s < 8) return 4'(s - 4);
    return 4'(s + 1);
  endfunction

  task automatic test_random();
    int ct;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(0, 99) < 60)
        issue(2'($urandom), $urandom, $urandom, rand_src_tag(), rand_src_tag());
      if ($urandom_range(0, 99) < 60) begin
        ct = int'($urandom_range(0, 5));
        cdb((ct < 4) ? 4'(ct) : 4'(ct + 5), $urandom);
      end
      bus.exec_ready = ($urandom_range(0, 99) < 50);
      clk_step();
      n_checks++;
      if (bus.is_full !== e_full || bus.issue_tag !== 4'(e_itag)) begin
        n_fail++;
        $display("FAIL rand_alloc cyc=%0d: full=%0b itag=%0d, want %0b %0d",
                 cyc, bus.is_full, bus.issue_tag, e_full, e_itag);
      end
      n_checks++;
      if (bus.exec_valid !== e_valid) begin
        n_fail++;
        $display("FAIL rand_valid cyc=%0d: valid=%0b, want %0b", cyc, bus.exec_valid, e_valid);
      end
      if (e_valid) begin
        n_checks++;
        if (bus.exec_tag !== 4'(e_tag) || bus.exec_op !== e_op || bus.exec_a !== e_a || bus.exec_b !== e_b) begin
          n_fail++;
          $display("FAIL rand_offer cyc=%0d: tag=%0d op=%0d a=%0h b=%0h, want %0d %0d %0h %0h",
                   cyc, bus.exec_tag, bus.exec_op, bus.exec_a, bus.exec_b, e_tag, e_op, e_a, e_b);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive_idle();
    model_clear();
    #12;
    rst = 1'b0;
    test_reset();
    test_direct_issue();
    test_wait_capture();
    test_bypass();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
